// File: rtl/result_write_arbiter.sv
// -----------------------------------------------------------------------------
// result_write_arbiter
//
// Lets three result channels share one capture-RAM write port. A round-robin
// arbiter grants one channel at a time over a req/ack handshake. Each accepted
// byte is tagged with its channel ID and written to the next RAM address. The
// block keeps per-channel and total write counts, detects a full RAM, and lets
// the host read counters and status or issue a clear.
//
// Build option:
//   RESULT_ARB_FIXED_PRIO_EN - when defined, fixed priority ch1 > ch2 > ch3;
//                              rr_ptr is held at 0. When undefined, round-robin.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   req[2:0]              per-channel request (bit0=ch1 .. bit2=ch3)
//   data1..data3          channel payloads
//   ack[2:0]              one-cycle capture acknowledge
//   ram_wren/ram_wraddress/ram_data  RAM write port, data = {tag, byte}
//   full                  RAM holds 2**ADDR_W entries
//   chipselect/read/address/readdata host slave read interface
//     0 wr_ptr, 1..3 cnt1..cnt3, 4 status, 7 clear (reads 0), others FFFF
// -----------------------------------------------------------------------------
module result_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        req,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    output logic [2:0]        ack,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W+1:0] ram_data,
    output logic              full,
    input  logic              chipselect,
    input  logic              read,
    input  logic [2:0]        address,
    output logic [15:0]       readdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt1_q, cnt1_d;
    logic [ADDR_W:0]   cnt2_q, cnt2_d;
    logic [ADDR_W:0]   cnt3_q, cnt3_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic              full_q, full_d;
    logic [2:0]        ack_q, ack_d;
    logic              ram_wren_q, ram_wren_d;
    logic [ADDR_W-1:0] ram_wraddress_q, ram_wraddress_d;
    logic [DATA_W+1:0] ram_data_q, ram_data_d;
    logic [15:0]       readdata_q, readdata_d;

    logic              clear_s;
    logic [1:0]        pick_s;
    logic [DATA_W-1:0] payload_s;

    // First requesting channel in rotation order starting at ptr.
    // Only meaningful when r is non-zero.
    function automatic logic [1:0] pick_grant(input logic [2:0] r, input logic [1:0] ptr);
        logic [1:0] g;
        g = 2'd0;
        case (ptr)
            2'd1: begin
                if (r[1])      g = 2'd1;
                else if (r[2]) g = 2'd2;
                else           g = 2'd0;
            end
            2'd2: begin
                if (r[2])      g = 2'd2;
                else if (r[0]) g = 2'd0;
                else           g = 2'd1;
            end
            default: begin
                if (r[0])      g = 2'd0;
                else if (r[1]) g = 2'd1;
                else           g = 2'd2;
            end
        endcase
        return g;
    endfunction

    // Rotation successor of a channel index: 0->1->2->0.
    function automatic logic [1:0] next_chan(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    assign clear_s = chipselect & read & (address == 3'd7);

    // Grant selection and payload mux for the channel being considered.
    always_comb begin
        pick_s    = pick_grant(req, rr_ptr_q);
        payload_s = '0;
        case (pick_s)
            2'd0:    payload_s = data1;
            2'd1:    payload_s = data2;
            default: payload_s = data3;
        endcase
    end

    // Arbiter FSM next-state, counter and RAM-port logic.
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        cnt1_d          = cnt1_q;
        cnt2_d          = cnt2_q;
        cnt3_d          = cnt3_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        full_d          = full_q;
        ack_d           = 3'b000;
        ram_wren_d      = 1'b0;
        ram_wraddress_d = ram_wraddress_q;
        ram_data_d      = ram_data_q;

        case (state_q)
            ST_IDLE: begin
                if (full_q) begin
                    state_d = ST_FULL;
                end else if (req != 3'b000) begin
                    grant_d         = pick_s;
                    ack_d           = 3'b001 << pick_s;
                    ram_wren_d      = 1'b1;
                    ram_wraddress_d = wr_ptr_q[ADDR_W-1:0];
                    ram_data_d      = {pick_s, payload_s};
                    state_d         = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // req is not looked at here, so a requester that keeps req
                // high for one cycle after ack is not captured twice.
                if (wr_ptr_q != DEPTH) begin
                    wr_ptr_d = wr_ptr_q + ONE;
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                case (grant_q)
                    2'd0:    cnt1_d = cnt1_q + ONE;
                    2'd1:    cnt2_d = cnt2_q + ONE;
                    2'd2:    cnt3_d = cnt3_q + ONE;
                    default: cnt1_d = cnt1_q;
                endcase
                rr_ptr_d = next_chan(grant_q);
                if (wr_ptr_d == DEPTH) begin
                    full_d  = 1'b1;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                full_d  = 1'b1;
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear beats everything, including the increment of a finishing
        // write; the RAM write of that cycle has already been presented.
        if (clear_s) begin
            wr_ptr_d   = '0;
            cnt1_d     = '0;
            cnt2_d     = '0;
            cnt3_d     = '0;
            full_d     = 1'b0;
            rr_ptr_d   = 2'd0;
            state_d    = ST_IDLE;
            ack_d      = 3'b000;
            ram_wren_d = 1'b0;
        end else begin
            state_d = state_d;
        end

`ifdef RESULT_ARB_FIXED_PRIO_EN
        // Fixed priority: rotation always starts at ch1.
        rr_ptr_d = 2'd0;
`endif
    end

    // Host register read mux; zero when not strobed.
    always_comb begin
        readdata_d = 16'h0000;
        if (chipselect && read) begin
            case (address)
                3'd0:    readdata_d = 16'(wr_ptr_q);
                3'd1:    readdata_d = 16'(cnt1_q);
                3'd2:    readdata_d = 16'(cnt2_q);
                3'd3:    readdata_d = 16'(cnt3_q);
                3'd4:    readdata_d = {12'h000, full_q, rr_ptr_q, (state_q == ST_WRITE)};
                3'd7:    readdata_d = 16'h0000;
                default: readdata_d = 16'hFFFF;
            endcase
        end else begin
            readdata_d = 16'h0000;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            cnt1_q          <= '0;
            cnt2_q          <= '0;
            cnt3_q          <= '0;
            rr_ptr_q        <= 2'd0;
            grant_q         <= 2'd0;
            full_q          <= 1'b0;
            ack_q           <= 3'b000;
            ram_wren_q      <= 1'b0;
            ram_wraddress_q <= '0;
            ram_data_q      <= '0;
            readdata_q      <= 16'h0000;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            cnt1_q          <= cnt1_d;
            cnt2_q          <= cnt2_d;
            cnt3_q          <= cnt3_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            full_q          <= full_d;
            ack_q           <= ack_d;
            ram_wren_q      <= ram_wren_d;
            ram_wraddress_q <= ram_wraddress_d;
            ram_data_q      <= ram_data_d;
            readdata_q      <= readdata_d;
        end
    end

    assign ack           = ack_q;
    assign ram_wren      = ram_wren_q;
    assign ram_wraddress = ram_wraddress_q;
    assign ram_data      = ram_data_q;
    assign full          = full_q;
    assign readdata      = readdata_q;

endmodule
